// File: rtl/nmr_ctrl_in_pkg.sv
// Shared register map, debouncer state type and helpers for the NMR control-input capture block.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a (no handshake; the block is a plain Avalon-MM slave with fixed timing).
package nmr_ctrl_in_pkg;

  // Word addresses on the lightweight bus
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd1;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CFG  = 3'd3;
  localparam logic [2:0] ADDR_EVENT_CNT = 3'd4;

  // EDGE_CFG field positions: rising enables at the bottom, falling enables in the upper half
  localparam int EDGE_CFG_RISE_LSB = 0;
  localparam int EDGE_CFG_FALL_LSB = 16;

  localparam int EVENT_CNT_W = 16;

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } deb_state_e;

  // Number of set bits in a vector of up to 16 inputs
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/nmr_ctrl_in_debounce.sv
// One input bit: SYNC_STAGES-flop synchronizer followed by a stable-count debouncer.
// Latency: a held change reaches deb_o DEBOUNCE_CYCLES cycles after the synchronizer output flips.
// Backpressure: none; the level is free-running and always valid.
module nmr_ctrl_in_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic deb_o
);
  import nmr_ctrl_in_pkg::*;

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  deb_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign deb_o    = lvl_q;

  // Shift the asynchronous pin through the synchronizer chain
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  // Count consecutive mismatch cycles; accept the new level once the count completes.
  // With a single-cycle filter CNT_LAST is 0, so the STABLE branch toggles immediately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    case (state_q)
      STABLE: begin
        if (sync_lvl != lvl_q) begin
          if (cnt_q == CNT_LAST) begin
            lvl_d = ~lvl_q;
          end else begin
            state_d = COUNT;
            cnt_d   = CW'(1);
          end
        end
      end
      COUNT: begin
        if (sync_lvl == lvl_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          lvl_d   = ~lvl_q;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Debouncer state register; reset discards any count in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

endmodule

// File: rtl/nmr_ctrl_in_capture.sv
// Conditioned capture of the NMR control inputs: debounce, sticky edge flags, event count, maskable irq.
// Latency: read data 1 cycle after address; flags/count 1 cycle after deb changes, irq 1 cycle after flags.
// Backpressure: none; writes take effect on the strobe edge, reads need no strobe.
module nmr_ctrl_in_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  import nmr_ctrl_in_pkg::*;

  logic [WIDTH-1:0]       deb;
  logic [WIDTH-1:0]       deb_dly_q;
  logic [WIDTH-1:0]       rise, fall, edges;
  logic [WIDTH-1:0]       irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]       edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0]       rise_en_q, rise_en_d;
  logic [WIDTH-1:0]       fall_en_q, fall_en_d;
  logic [WIDTH-1:0]       w1c;
  logic [EVENT_CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic [EVENT_CNT_W-1:0] cnt_base;
  logic [EVENT_CNT_W:0]   cnt_sum;
  logic [31:0]            readdata_q, readdata_d;
  logic                   irq_q, irq_d;
  logic                   unused_wdata;

  // Only the low WIDTH bits of each field are implemented
  assign unused_wdata = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    nmr_ctrl_in_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .async_i(in_port[g]),
      .deb_o  (deb[g])
    );
  end

  assign rise  = deb & ~deb_dly_q & rise_en_q;
  assign fall  = ~deb & deb_dly_q & fall_en_q;
  assign edges = rise | fall;

  // Register writes, sticky flags (new edge beats W1C) and saturating event count
  always_comb begin
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c        = '0;
    if (write) begin
      case (address)
        ADDR_IRQ_MASK: irq_mask_d = writedata[WIDTH-1:0];
        ADDR_EDGE_CAP: w1c        = writedata[WIDTH-1:0];
        ADDR_EDGE_CFG: begin
          rise_en_d = writedata[EDGE_CFG_RISE_LSB +: WIDTH];
          fall_en_d = writedata[EDGE_CFG_FALL_LSB +: WIDTH];
        end
        default: ;
      endcase
    end
    edge_cap_d  = (edge_cap_q & ~w1c) | edges;
    // A clearing write restarts from zero but still counts this cycle's edges
    cnt_base    = (write && (address == ADDR_EVENT_CNT)) ? '0 : event_cnt_q;
    cnt_sum     = {1'b0, cnt_base} + (EVENT_CNT_W + 1)'(popcount16(16'(edges)));
    event_cnt_d = cnt_sum[EVENT_CNT_W] ? '1 : cnt_sum[EVENT_CNT_W-1:0];
  end

  // Read mux and interrupt; both registered so the bus sees one cycle of latency
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:      readdata_d[WIDTH-1:0]                   = deb;
      ADDR_IRQ_MASK:  readdata_d[WIDTH-1:0]                   = irq_mask_q;
      ADDR_EDGE_CAP:  readdata_d[WIDTH-1:0]                   = edge_cap_q;
      ADDR_EDGE_CFG: begin
        readdata_d[EDGE_CFG_RISE_LSB +: WIDTH] = rise_en_q;
        readdata_d[EDGE_CFG_FALL_LSB +: WIDTH] = fall_en_q;
      end
      ADDR_EVENT_CNT: readdata_d[EVENT_CNT_W-1:0]             = event_cnt_q;
      default:        readdata_d                              = '0;
    endcase
    irq_d = |(edge_cap_q & irq_mask_q);
  end

  // State registers; EDGE_CFG comes out of reset with rising edges enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_dly_q   <= '0;
      irq_mask_q  <= '0;
      edge_cap_q  <= '0;
      rise_en_q   <= '1;
      fall_en_q   <= '0;
      event_cnt_q <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      deb_dly_q   <= deb;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      event_cnt_q <= event_cnt_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nmr_ctrl_in_capture.sv
// Bench for nmr_ctrl_in_capture: directed register/edge scenarios with a queued-expectation checker.
// Latency: a read issued between edges X and X+1 is checked after X+1 (readdata = state after X; irq = after X+1).
// Backpressure: none; one read per cycle, a second instance with a 1-cycle filter drives the saturation case.
module tb_nmr_ctrl_in_capture;
  import nmr_ctrl_in_pkg::*;

  logic        clk         = 1'b0;
  logic        reset       = 1'b1;
  logic [2:0]  address     = '0;
  logic        write       = 1'b0;
  logic [31:0] writedata   = '0;
  logic [7:0]  in_port     = '0;
  logic [7:0]  in_port_sat = '0;
  logic [31:0] readdata, readdata_sat;
  logic        irq, irq_sat;

  logic        rd_issue    = 1'b0;
  logic        rd_out_vld  = 1'b0;
  logic        sat_tog     = 1'b0;
  int          n_total     = 0;
  int          n_pass      = 0;

  typedef struct {
    logic        sel;
    logic [31:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
    string       name;
  } item_t;
  item_t sb_q[$];

  always #5 clk = ~clk;

  nmr_ctrl_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) u_dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  nmr_ctrl_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_sat (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(readdata_sat), .in_port(in_port_sat), .irq(irq_sat)
  );

  // Read output is presented one cycle after the read is issued
  always @(posedge clk) rd_out_vld <= rd_issue;

  // Fast toggler for the saturation instance
  initial begin
    forever begin
      @(negedge clk);
      if (sat_tog) in_port_sat = ~in_port_sat;
    end
  end

  // Monitor: pop the oldest expectation whenever a read result is presented
  initial begin : monitor
    item_t       it;
    logic [31:0] act;
    logic        act_irq;
    forever begin
      @(negedge clk);
      if (rd_out_vld) begin
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_underflow: read result 0x%08h with no expectation queued", readdata);
        end else begin
          it  = sb_q.pop_front();
          act = it.sel ? readdata_sat : readdata;
          if (act === it.exp_rd) n_pass++;
          else $display("FAIL %s: readdata 0x%08h, expected 0x%08h", it.name, act, it.exp_rd);
          if (it.chk_irq) begin
            n_total++;
            act_irq = it.sel ? irq_sat : irq;
            if (act_irq === it.exp_irq) n_pass++;
            else $display("FAIL %s_irq: irq %0b, expected %0b", it.name, act_irq, it.exp_irq);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic rdc(input logic sel, input logic [2:0] a, input logic [31:0] e,
                     input logic ci, input logic ei, input string nm);
    item_t it;
    it.sel     = sel;
    it.exp_rd  = e;
    it.chk_irq = ci;
    it.exp_irq = ei;
    it.name    = nm;
    sb_q.push_back(it);
    address  = a;
    rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    rdc(1'b0, a, e, 1'b0, 1'b0, nm);
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values of every address
    rdc(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, "rst_data");
    rd(3'd1, 32'h0,        "rst_irq_mask");
    rd(3'd2, 32'h0,        "rst_edge_cap");
    rd(3'd3, 32'h0000_00FF, "rst_edge_cfg");
    rd(3'd4, 32'h0,        "rst_event_cnt");
    rd(3'd5, 32'h0,        "rst_addr5");
    rd(3'd6, 32'h0,        "rst_addr6");
    rd(3'd7, 32'h0,        "rst_addr7");

    // Unused addresses ignore writes; IRQ_MASK keeps only WIDTH bits
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, 32'h0,        "addr7_after_wr");
    rd(3'd3, 32'h0000_00FF, "cfg_after_wr7");
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, 32'h0000_00FF, "irq_mask_width");
    wr(3'd1, 32'h0000_0001);
    rd(3'd1, 32'h0000_0001, "irq_mask_rw");

    // Bit 0 rises: change lands after edge E; deb after E+18, flags E+19, irq E+20
    in_port = 8'h01;
    repeat (17) @(negedge clk);
    rdc(1'b0, 3'd0, 32'h00, 1'b1, 1'b0, "deb0_before");
    rdc(1'b0, 3'd0, 32'h01, 1'b1, 1'b0, "deb0_rise");
    rdc(1'b0, 3'd2, 32'h01, 1'b1, 1'b1, "cap0_rise");
    rd(3'd4, 32'd1, "cnt0_rise");

    // Clear, then a 10-cycle glitch on bit 3 must leave no trace
    wr(3'd2, 32'h0000_00FF);
    wr(3'd4, 32'h0);
    rdc(1'b0, 3'd2, 32'h0, 1'b1, 1'b0, "cap_cleared");
    rd(3'd4, 32'h0, "cnt_cleared");
    in_port = 8'h09;
    repeat (10) @(negedge clk);
    in_port = 8'h01;
    repeat (30) @(negedge clk);
    rd(3'd0, 32'h01, "glitch_data");
    rd(3'd2, 32'h00, "glitch_cap");
    rd(3'd4, 32'h00, "glitch_cnt");

    // Falling-only configuration on bit 5
    wr(3'd3, 32'h00FF_0000);
    rd(3'd3, 32'h00FF_0000, "cfg_fall_only");
    in_port = 8'h21;
    repeat (25) @(negedge clk);
    rd(3'd0, 32'h21, "b5_high_data");
    rd(3'd2, 32'h00, "b5_rise_ignored");
    in_port = 8'h01;
    repeat (25) @(negedge clk);
    rd(3'd2, 32'h20, "b5_fall_cap");
    rd(3'd4, 32'd1,  "b5_fall_cnt");

    // W1C of bit 5 on the same edge a new fall captures: the set wins
    in_port = 8'h21;
    repeat (25) @(negedge clk);
    in_port = 8'h01;
    repeat (18) @(negedge clk);
    wr(3'd2, 32'h0000_0020);
    rd(3'd2, 32'h20, "w1c_vs_set");
    rd(3'd4, 32'd2,  "w1c_vs_set_cnt");
    wr(3'd2, 32'h0000_0020);
    rd(3'd2, 32'h00, "w1c_clear");

    // All eight bits rise together
    wr(3'd3, 32'h0000_00FF);
    in_port = 8'h00;
    repeat (25) @(negedge clk);
    wr(3'd2, 32'h0000_00FF);
    wr(3'd4, 32'h0);
    rd(3'd4, 32'h0, "all_pre_cnt");
    in_port = 8'hFF;
    repeat (17) @(negedge clk);
    rd(3'd4, 32'd0,  "all_cnt_before");
    rd(3'd4, 32'd0,  "all_cnt_edge_cycle");
    rd(3'd4, 32'd8,  "all_cnt_plus8");
    rd(3'd2, 32'hFF, "all_cap");

    // One-cycle reset in the middle of a debounce count on bit 0
    in_port = 8'h00;
    repeat (25) @(negedge clk);
    wr(3'd2, 32'h0000_00FF);
    wr(3'd4, 32'h0);
    in_port = 8'h01;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    rd(3'd2, 32'h00, "abort_nocap");
    repeat (4) @(negedge clk);
    rd(3'd0, 32'h00, "post_rst_deb_before");
    rd(3'd0, 32'h01, "post_rst_deb_rise");
    rd(3'd2, 32'h01, "post_rst_cap");
    rdc(1'b0, 3'd4, 32'd1, 1'b1, 1'b0, "post_rst_cnt");

    // Saturation on the single-cycle-filter instance, both edge polarities enabled
    wr(3'd3, 32'hFFFF_FFFF);
    rdc(1'b1, 3'd3, 32'h00FF_00FF, 1'b0, 1'b0, "sat_cfg_width");
    sat_tog = 1'b1;
    repeat (9000) @(negedge clk);
    rdc(1'b1, 3'd4, 32'h0000_FFFF, 1'b0, 1'b0, "sat_hold");
    wr(3'd4, 32'h0);
    rdc(1'b1, 3'd4, 32'd8,  1'b0, 1'b0, "clr_with_edges");
    rdc(1'b1, 3'd4, 32'd16, 1'b0, 1'b0, "after_clr_count");
    sat_tog = 1'b0;
    repeat (6) @(negedge clk);
    wr(3'd4, 32'h0);
    rdc(1'b1, 3'd4, 32'd0, 1'b0, 1'b0, "clr_idle");

    repeat (3) @(negedge clk);
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
